func_seq: RTL
=============

# func_seq

Self-checking request sequencer: the initiator end of the `func` start/busy handshake. On a `go_i` pulse it walks a fixed table of operand pairs. For each pair it drives `a`/`b` and a one-cycle `start` into `func`, waits for the busy cycle to complete, captures `y`, and compares it against the expected value. It sits beside `func` on the FPGA top level as a built-in self test and reports pass/fail counts and the index of the first failing vector.

## Interface
- `N_VEC`, default 10: number of table vectors; 1..15.
- `TIMEOUT`, default 255: maximum cycles spent in any one wait state before the vector is declared failed.
- `CW`, default `$clog2(N_VEC+1)`: width of the counters and the index.

Ports:
- `clk_i`  in  1  single clock; all state changes on its rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `go_i`  in  1  run request; honoured in IDLE and DONE, ignored otherwise.
- `busy_o`  out  1  high while a run is in progress.
- `done_o`  out  1  high in DONE; held until the next `go_i` or reset.
- `start_o`  out  1  to `func.start_i`; high for exactly one cycle per vector.
- `a_bo`  out  8  to `func.a_bi`.
- `b_bo`  out  8  to `func.b_bi`.
- `busy_i`  in  1  from `func.busy_o`.
- `y_bi`  in  11  from `func.y_bo`.
- `pass_cnt_bo`  out  CW  vectors matched.
- `fail_cnt_bo`  out  CW  vectors mismatched or timed out.
- `err_o`  out  1  sticky; set on the first failure of the run.
- `err_idx_bo`  out  CW  index of the first failure; valid when `err_o` is high.

## Operation
- Expected result: y = 3·a + 2·floor(cbrt(b)), 11-bit unsigned. The table stores this value precomputed; no arithmetic is done at run time.
- The table holds the vectors in this order, as (a, b, y): (0,0,0), (1,1,5), (2,2,8), (3,3,11), (4,4,14), (5,5,17), (6,6,20), (7,7,23), (32,128,106), (48,192,154).
- FSM states:
  - **IDLE**
    - On `go_i`: clear counters, `err_o`, `err_idx_bo` and `idx`, then go to ISSUE.
  - **ISSUE**
    - Register `a_bo`/`b_bo` from table[idx] and drive `start_o` = 1.
    - Clear the timer and go to WAIT_ACK.
  - **WAIT_ACK**
    - `start_o` = 0.
    - `busy_i` = 1: clear the timer and go to WAIT_DONE.
    - Timer reaches TIMEOUT: mark a timeout and go to CHECK.
  - **WAIT_DONE**
    - `busy_i` = 0: capture `y_bi` into `y_q` and go to CHECK.
    - Timer reaches TIMEOUT: mark a timeout and go to CHECK.
  - **CHECK**
    - Pass = (no timeout) and (`y_q` == table[idx].y). Increment `pass_cnt` or `fail_cnt` accordingly.
    - On a fail with `err_o` = 0: set `err_o` and latch `err_idx` = idx.
    - idx == N_VEC-1: go to DONE. Otherwise increment idx and go to ISSUE.
  - **DONE**
    - `done_o` = 1.
    - `go_i` restarts exactly as from IDLE, and `done_o` drops on that same edge.
- `a_bo`/`b_bo` are held stable from ISSUE through CHECK.
- `start_o` is never asserted while `busy_i` is high.
- `go_i` during a run has no effect.

## Timing
- Reset values: every output is 0, and the FSM is in IDLE. The reset is asynchronous, so `start_o` drops immediately even in the middle of ISSUE.
- Reset during a run abandons it. Counters read 0, and a new `go_i` after release gives a clean run.
- `go_i` high at edge k puts `start_o` high in cycle k+1.
- Per-vector cost with a `func` whose busy lasts B cycles starting one cycle after start: 1 (ISSUE) + 1 (WAIT_ACK) + B (WAIT_DONE) + 1 (CHECK).
- `busy_i` already high in the same cycle as `start_o` is accepted on the next edge as an ACK.
- A timed-out vector costs TIMEOUT+1 cycles in the state that timed out; the run then continues with the next vector.
- Counters cannot overflow, since `N_VEC` ≤ 15 and CW covers N_VEC.
- Timer width is `$clog2(TIMEOUT+1)`.

## Structure
- Shared header `func_defs.vh` holds:
  - operand width 8 and result width 11;
  - the state encodings;
  - the default N_VEC and TIMEOUT.
- Sub-module `func_vec_rom`: a combinational case on index returning {a, b, y}. It is the only place the vectors live.
- The FSM, timer, counters and checker live in `func_seq`.

## Test plan
- Behavioural `func` model (busy rises 1 cycle after start, lasts 20 cycles, returns the correct y), single `go_i` → `done_o`, `pass_cnt_bo`=10, `fail_cnt_bo`=0, `err_o`=0. Bench also checks exactly 10 one-cycle `start_o` pulses.
- Model returns 105 instead of 106 for a=32, b=128 → pass=9, fail=1, `err_o`=1, `err_idx_bo`=8.
- Model never raises busy → every vector times out after 256 cycles; fail=10, `err_idx_bo`=0, `done_o` reached.
- `rst_i` pulsed during WAIT_DONE of vector 3 → `start_o`, `busy_o` and all counters read 0 before the next edge. A following `go_i` yields pass=10.
- `go_i` pulsed at vector 5 mid-run → no restart, final pass=10. `go_i` in DONE → `done_o` drops on that edge and a second run completes with pass=10.
- Integration with the real `func` → pass=10, fail=0.

Source files
------------

// File: rtl/func_seq_pkg.sv
// Shared widths, defaults, FSM encoding and vector record for the func self-test sequencer.
package func_seq_pkg;

  localparam int OP_W        = 8;
  localparam int RES_W       = 11;
  localparam int N_VEC_DEF   = 10;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_CHECK     = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]  a;
    logic [OP_W-1:0]  b;
    logic [RES_W-1:0] y;
  } vec_t;

endpackage

// File: rtl/func_seq_vec_rom.sv
// Operand/expected-result table for the func self-test; y = 3a + 2*floor(cbrt(b)), precomputed.
module func_vec_rom
  import func_seq_pkg::*;
(
  input  logic [3:0] idx_i,
  output vec_t       vec_o
);

  always_comb begin
    vec_o = '0;
    case (idx_i)
      4'd0: vec_o = '{a: 8'd0,  b: 8'd0,   y: 11'd0};
      4'd1: vec_o = '{a: 8'd1,  b: 8'd1,   y: 11'd5};
      4'd2: vec_o = '{a: 8'd2,  b: 8'd2,   y: 11'd8};
      4'd3: vec_o = '{a: 8'd3,  b: 8'd3,   y: 11'd11};
      4'd4: vec_o = '{a: 8'd4,  b: 8'd4,   y: 11'd14};
      4'd5: vec_o = '{a: 8'd5,  b: 8'd5,   y: 11'd17};
      4'd6: vec_o = '{a: 8'd6,  b: 8'd6,   y: 11'd20};
      4'd7: vec_o = '{a: 8'd7,  b: 8'd7,   y: 11'd23};
      4'd8: vec_o = '{a: 8'd32, b: 8'd128, y: 11'd106};
      4'd9: vec_o = '{a: 8'd48, b: 8'd192, y: 11'd154};
      default: vec_o = '0;
    endcase
  end

endmodule

// File: rtl/func_seq.sv
// Built-in self test driving func's start/busy handshake through a fixed vector table.
// Reports pass/fail counts, a sticky error flag and the index of the first failing vector.
module func_seq
  import func_seq_pkg::*;
#(
  parameter int N_VEC   = N_VEC_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CW      = $clog2(N_VEC + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             go_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             start_o,
  output logic [OP_W-1:0]  a_bo,
  output logic [OP_W-1:0]  b_bo,
  input  logic             busy_i,
  input  logic [RES_W-1:0] y_bi,
  output logic [CW-1:0]    pass_cnt_bo,
  output logic [CW-1:0]    fail_cnt_bo,
  output logic             err_o,
  output logic [CW-1:0]    err_idx_bo
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t           state_q;
  logic [CW-1:0]    idx_q;
  logic [TW-1:0]    timer_q;
  logic             to_q;
  logic [RES_W-1:0] y_q;
  logic [RES_W-1:0] exp_y_q;
  logic [3:0]       rom_idx_d;
  logic             pass_d;
  logic             last_d;
  vec_t             vec;

  // Operands are loaded on the edge entering ISSUE so start_o and a/b appear together;
  // the ROM therefore looks at the vector about to be issued, not the one being checked.
  always_comb begin
    rom_idx_d = 4'd0;
    if (state_q == ST_CHECK) rom_idx_d = 4'(idx_q + CW'(1));
  end

  func_vec_rom u_rom (
    .idx_i (rom_idx_d),
    .vec_o (vec)
  );

  always_comb begin
    pass_d = !to_q && (y_q == exp_y_q);
    last_d = (idx_q == CW'(N_VEC - 1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      to_q        <= 1'b0;
      y_q         <= '0;
      exp_y_q     <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      start_o     <= 1'b0;
      a_bo        <= '0;
      b_bo        <= '0;
      pass_cnt_bo <= '0;
      fail_cnt_bo <= '0;
      err_o       <= 1'b0;
      err_idx_bo  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (go_i) begin
            idx_q       <= '0;
            pass_cnt_bo <= '0;
            fail_cnt_bo <= '0;
            err_o       <= 1'b0;
            err_idx_bo  <= '0;
            a_bo        <= vec.a;
            b_bo        <= vec.b;
            exp_y_q     <= vec.y;
            start_o     <= 1'b1;
            busy_o      <= 1'b1;
            done_o      <= 1'b0;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          start_o <= 1'b0;
          timer_q <= '0;
          to_q    <= 1'b0;
          state_q <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (busy_i) begin
            timer_q <= '0;
            state_q <= ST_WAIT_DONE;
          end else if (timer_q == TW'(TIMEOUT)) begin
            to_q    <= 1'b1;
            state_q <= ST_CHECK;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!busy_i) begin
            y_q     <= y_bi;
            state_q <= ST_CHECK;
          end else if (timer_q == TW'(TIMEOUT)) begin
            to_q    <= 1'b1;
            state_q <= ST_CHECK;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_CHECK: begin
          if (pass_d) begin
            pass_cnt_bo <= pass_cnt_bo + CW'(1);
          end else begin
            fail_cnt_bo <= fail_cnt_bo + CW'(1);
            if (!err_o) begin
              err_o      <= 1'b1;
              err_idx_bo <= idx_q;
            end
          end
          if (last_d) begin
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            idx_q   <= idx_q + CW'(1);
            a_bo    <= vec.a;
            b_bo    <= vec.b;
            exp_y_q <= vec.y;
            start_o <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
